pump_commander: RTL and testbench



---
 rtl/pump_commander_pkg.sv | 27 ++
 rtl/pump_commander_hold_timer.sv | 43 ++++
 rtl/pump_commander.sv | 143 ++++++++++++++
 tb/tb_pump_commander.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/pump_commander_pkg.sv
// rtl/pump_commander_pkg.sv - shared command codes and pump state encodings
//
// Purpose: single definition of the pump interface encodings, shared by the
//          commander and the pump controller.
// Contents:
//    cmd_e    - 2-bit command codes carried with the update strobe
//    mirror_e - commanded pump state (off / standby / working)
//    LOW/HIGH - sensor and enable levels
package pump_commander_pkg;

   typedef enum logic [1:0] {
      CMD_TURN_OFF   = 2'b00,
      CMD_TURN_ON    = 2'b01,
      CMD_STOP_PUMP  = 2'b10,
      CMD_START_PUMP = 2'b11
   } cmd_e;

   typedef enum logic [1:0] {
      ST_OFF     = 2'd0,
      ST_STANDBY = 2'd1,
      ST_WORKING = 2'd2
   } mirror_e;

   localparam logic LOW  = 1'b0;
   localparam logic HIGH = 1'b1;

endpackage

// File: rtl/pump_commander_hold_timer.sv
// rtl/pump_commander_hold_timer.sv - loadable saturating down-counter
//
// Purpose: holds off an action for a programmable number of cycles. Loads
//          'value' when 'load' is high, otherwise counts down and sticks at 0.
// Ports:
//    clk     in          system clock
//    reset_n in          asynchronous active-low reset (count cleared to 0)
//    load    in          load 'value' this cycle (wins over decrement)
//    value   in  WIDTH   reload value
//    zero    out         count is 0 (hold-off expired)
module hold_timer #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic [WIDTH-1:0] value,
   output logic             zero
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = value;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/pump_commander.sv
// rtl/pump_commander.sv - pump command issuer with run/rest/spacing hold-offs
//
// Purpose: watches the master enable and the two tank level sensors and
//          issues single-cycle update strobes with 2-bit commands to the pump
//          controller, keeping a mirror of the commanded pump state.
// Ports:
//    clk        in      system clock
//    reset_n    in      asynchronous active-low reset
//    enable     in      master power request (1 = system on)
//    level_low  in      tank below low mark
//    level_high in      tank at high mark
//    update     out     single-cycle command strobe
//    command    out 2   command code, valid with update, held afterwards
//    mirror     out 2   commanded pump state: 0 off, 1 standby, 2 working
//    fault      out     both level sensors high (registered, not latched)
module pump_commander
   import pump_commander_pkg::*;
#(
   parameter int GAP      = 4,
   parameter int MIN_RUN  = 8,
   parameter int MIN_REST = 6
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       enable,
   input  logic       level_low,
   input  logic       level_high,
   output logic       update,
   output logic [1:0] command,
   output logic [1:0] mirror,
   output logic       fault
);

   localparam int GW = $clog2(GAP + 1);
   localparam int RW = $clog2(MIN_RUN + 1);
   localparam int SW = $clog2(MIN_REST + 1);

   localparam logic [GW-1:0] GAP_LOAD  = GW'(GAP - 1);
   localparam logic [RW-1:0] RUN_LOAD  = RW'(MIN_RUN - 1);
   localparam logic [SW-1:0] REST_LOAD = SW'(MIN_REST - 1);

   logic    en_q, lo_q, hi_q, fault_q;
   logic    update_q, update_d;
   cmd_e    command_q, command_d;
   mirror_e mirror_q, mirror_d;

   logic gap_zero, run_zero, rest_zero;
   logic run_load, rest_load;

   // Input registers and the conflict flag derived from them.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         en_q    <= LOW;
         lo_q    <= LOW;
         hi_q    <= LOW;
         fault_q <= LOW;
      end else begin
         en_q    <= enable;
         lo_q    <= level_low;
         hi_q    <= level_high;
         fault_q <= lo_q & hi_q;
      end
   end

   // Decision logic. Only one decision per gap window; a condition that was
   // blocked by the gap timer is simply re-evaluated once it expires.
   always_comb begin
      update_d  = 1'b0;
      command_d = command_q;
      mirror_d  = mirror_q;
      if (gap_zero) begin
         if (mirror_q != ST_OFF && en_q == LOW) begin
            update_d  = 1'b1;
            command_d = CMD_TURN_OFF;
            mirror_d  = ST_OFF;
         end else if (mirror_q == ST_WORKING && fault_q == HIGH) begin
            update_d  = 1'b1;
            command_d = CMD_STOP_PUMP;
            mirror_d  = ST_STANDBY;
         end else if (mirror_q == ST_OFF && en_q == HIGH) begin
            update_d  = 1'b1;
            command_d = CMD_TURN_ON;
            mirror_d  = ST_STANDBY;
         end else if (mirror_q == ST_WORKING && hi_q == HIGH && run_zero) begin
            update_d  = 1'b1;
            command_d = CMD_STOP_PUMP;
            mirror_d  = ST_STANDBY;
         end else if (mirror_q == ST_STANDBY && lo_q == HIGH && hi_q == LOW &&
                      rest_zero && fault_q == LOW) begin
            update_d  = 1'b1;
            command_d = CMD_START_PUMP;
            mirror_d  = ST_WORKING;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         update_q  <= 1'b0;
         command_q <= CMD_TURN_OFF;
         mirror_q  <= ST_OFF;
      end else begin
         update_q  <= update_d;
         command_q <= command_d;
         mirror_q  <= mirror_d;
      end
   end

   // Rest hold-off applies only after leaving working; power-up standby
   // leaves the rest timer untouched (already expired).
   assign run_load  = (mirror_d == ST_WORKING) && (mirror_q != ST_WORKING);
   assign rest_load = (mirror_d == ST_STANDBY) && (mirror_q == ST_WORKING);

   hold_timer #(.WIDTH(GW)) u_gap_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (update_d),
      .value   (GAP_LOAD),
      .zero    (gap_zero)
   );

   hold_timer #(.WIDTH(RW)) u_run_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (run_load),
      .value   (RUN_LOAD),
      .zero    (run_zero)
   );

   hold_timer #(.WIDTH(SW)) u_rest_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (rest_load),
      .value   (REST_LOAD),
      .zero    (rest_zero)
   );

   assign update  = update_q;
   assign command = command_q;
   assign mirror  = mirror_q;
   assign fault   = fault_q;

endmodule

// File: tb/tb_pump_commander.sv
// tb/tb_pump_commander.sv - self-checking bench for pump_commander
module tb_pump_commander;

   localparam int GAP      = 4;
   localparam int MIN_RUN  = 8;
   localparam int MIN_REST = 6;

   localparam logic [1:0] C_OFF   = 2'b00;
   localparam logic [1:0] C_ON    = 2'b01;
   localparam logic [1:0] C_STOP  = 2'b10;
   localparam logic [1:0] C_START = 2'b11;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       enable = 1'b0;
   logic       level_low = 1'b0;
   logic       level_high = 1'b0;
   logic       update;
   logic [1:0] command;
   logic [1:0] mirror;
   logic       fault;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int upd_count = 0;

   pump_commander #(
      .GAP      (GAP),
      .MIN_RUN  (MIN_RUN),
      .MIN_REST (MIN_REST)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .enable     (enable),
      .level_low  (level_low),
      .level_high (level_high),
      .update     (update),
      .command    (command),
      .mirror     (mirror),
      .fault      (fault)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural model: hold-offs are expressed as elapsed edge counts since
   // the last strobe, the last start and the last stop.
   int         m_edge;
   int         m_last_upd, m_last_start, m_last_stop;
   logic       r_en, r_lo, r_hi;
   logic       m_upd, m_fault;
   logic [1:0] m_cmd, m_mir;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_edge = 0;
         m_last_upd = -1000; m_last_start = -1000; m_last_stop = -1000;
         r_en = 0; r_lo = 0; r_hi = 0;
         m_upd = 0; m_fault = 0; m_cmd = C_OFF; m_mir = 0;
      end else begin
         logic       dec;
         logic [1:0] ncmd, nmir;
         m_edge = m_edge + 1;
         dec = 0; ncmd = m_cmd; nmir = m_mir;
         if (m_edge - m_last_upd >= GAP) begin
            if (m_mir != 0 && !r_en) begin
               dec = 1; ncmd = C_OFF; nmir = 0;
            end else if (m_mir == 2 && m_fault) begin
               dec = 1; ncmd = C_STOP; nmir = 1;
            end else if (m_mir == 0 && r_en) begin
               dec = 1; ncmd = C_ON; nmir = 1;
            end else if (m_mir == 2 && r_hi && (m_edge - m_last_start >= MIN_RUN)) begin
               dec = 1; ncmd = C_STOP; nmir = 1;
            end else if (m_mir == 1 && r_lo && !r_hi && !m_fault &&
                         (m_edge - m_last_stop >= MIN_REST)) begin
               dec = 1; ncmd = C_START; nmir = 2;
            end
         end
         m_upd = dec;
         if (dec) begin
            m_last_upd = m_edge;
            if (ncmd == C_START) m_last_start = m_edge;
            if (ncmd == C_STOP)  m_last_stop  = m_edge;
            m_cmd = ncmd;
            m_mir = nmir;
         end
         m_fault = r_lo & r_hi;
         r_en = enable; r_lo = level_low; r_hi = level_high;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      total = total + 1;
      if (act != exp) begin
         bad = bad + 1;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      chk("update",  int'(update),  int'(m_upd));
      chk("command", int'(command), int'(m_cmd));
      chk("mirror",  int'(mirror),  int'(m_mir));
      chk("fault",   int'(fault),   int'(m_fault));
      if (update) upd_count = upd_count + 1;
   end

   // Waits for the next strobe (bounded) and checks its command code.
   task automatic wait_upd(input string name, input logic [1:0] exp_cmd,
                           input int maxc, output int at);
      bit seen = 0;
      at = -1;
      for (int i = 0; i < maxc && !seen; i++) begin
         @(negedge clk);
         if (update) begin
            seen = 1;
            at = cyc;
         end
      end
      if (!seen) begin
         total = total + 1;
         bad = bad + 1;
         $display("FAIL %s: no update within %0d cycles, expected command %0d", name, maxc, exp_cmd);
      end else begin
         chk(name, int'(command), int'(exp_cmd));
      end
   endtask

   initial begin
      int t_on, t_st, t_sp, t_st2, t_off, t_on2, t_st3, t_sp3, t_st4, t_on3, cnt0;

      // Power-up
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (6) @(negedge clk);
      #1;
      chk("pwrup_updates", upd_count, 0);
      chk("pwrup_command", int'(command), 0);
      chk("pwrup_mirror",  int'(mirror), 0);

      // Turn on and start
      enable = 1'b1;
      @(negedge clk);
      level_low = 1'b1;
      wait_upd("turn_on", C_ON, 10, t_on);
      chk("mirror_standby", int'(mirror), 1);
      wait_upd("start", C_START, 12, t_st);
      chk("start_after_on", t_st - t_on, GAP);
      chk("mirror_working", int'(mirror), 2);

      // Minimum run, then minimum rest
      level_low = 1'b0; level_high = 1'b1;
      wait_upd("stop_run", C_STOP, 20, t_sp);
      chk("stop_after_start", t_sp - t_st, MIN_RUN);
      level_high = 1'b0; level_low = 1'b1;
      wait_upd("restart", C_START, 20, t_st2);
      chk("restart_after_stop", t_st2 - t_sp, MIN_REST);

      // Power-off override while working
      @(negedge clk);
      enable = 1'b0; level_low = 1'b0;
      wait_upd("turn_off", C_OFF, 20, t_off);
      chk("off_after_start", t_off - t_st2, GAP);
      chk("mirror_off", int'(mirror), 0);

      // Sensor conflict
      enable = 1'b1; level_low = 1'b1;
      wait_upd("turn_on2", C_ON, 10, t_on2);
      wait_upd("start3", C_START, 20, t_st3);
      level_high = 1'b1;
      wait_upd("fault_stop", C_STOP, 20, t_sp3);
      chk("fault_stop_after_start", t_sp3 - t_st3, GAP);
      chk("fault_flag", int'(fault), 1);
      #1 cnt0 = upd_count;
      repeat (20) @(negedge clk);
      #1;
      chk("no_start_in_conflict", upd_count - cnt0, 0);
      chk("conflict_mirror", int'(mirror), 1);

      // Async reset mid-run
      level_high = 1'b0;
      wait_upd("start4", C_START, 20, t_st4);
      repeat (2) @(negedge clk);
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("arst_mirror", int'(mirror), 0);
      chk("arst_update", int'(update), 0);
      chk("arst_command", int'(command), 0);
      repeat (3) @(negedge clk);
      level_low = 1'b0;
      reset_n = 1'b1;
      wait_upd("fresh_on", C_ON, 10, t_on3);
      chk("fresh_mirror", int'(mirror), 1);

      repeat (5) @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "timeout");
   end

endmodule
